// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet decoder: byte-0 bit positions,
// FSM state encoding and default screen limits.
package mouse_pkg;

    localparam int LEFT  = 0;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    localparam int X_MAX_DEF = 799;
    localparam int Y_MAX_DEF = 599;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_B0 = 2'd1,
        GOT_B1 = 2'd2
    } state_e;

endpackage

// File: rtl/mouse_axis_clamp.sv
// Combinational 13-bit signed position update for one axis, saturated to 0..MAX.
// The caller registers the result.
module mouse_axis_clamp #(
    parameter int MAX = 799
) (
    input  logic        [11:0] pos,
    input  logic signed [12:0] delta,
    output logic        [11:0] result
);

    localparam logic signed [12:0] MAX_S = 13'(MAX);

    logic signed [12:0] sum;

    always_comb begin
        sum = $signed({1'b0, pos}) + delta;
        if (sum < 0) begin
            result = '0;
        end else if (sum > MAX_S) begin
            result = MAX_S[11:0];
        end else begin
            result = sum[11:0];
        end
    end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Decodes 3-byte PS/2 mouse packets into saturating absolute cursor coordinates.
// Define MOUSE_OVERFLOW_DISCARD_EN to zero a delta whose overflow bit is set.
module mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter int X_MAX          = X_MAX_DEF,
    parameter int Y_MAX          = Y_MAX_DEF,
    parameter int X_INIT         = 400,
    parameter int Y_INIT         = 300,
    parameter int TIMEOUT_CYCLES = 130000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left,
    output logic        packet_strobe
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The idle cycle that would bring the count to TIMEOUT_CYCLES ends the packet instead.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               left_b0_q, left_b0_d;
    logic               xsign_q, xsign_d;
    logic               ysign_q, ysign_d;
    logic [7:0]         dx_q, dx_d;
`ifdef MOUSE_OVERFLOW_DISCARD_EN
    logic               xovf_q, xovf_d;
    logic               yovf_q, yovf_d;
`endif

    logic [11:0]        xpos_q, xpos_d, ypos_q, ypos_d;
    logic               left_q, left_d, strobe_q, strobe_d;

    logic               accept_b0, accept_b1, apply;
    logic signed [8:0]  dx9, dy9;
    logic signed [12:0] dx_ext, dy_neg;
    logic [11:0]        x_new, y_new;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_valid && rx_data[SYNC]) state_d = GOT_B0;
            end
            GOT_B0, GOT_B1: begin
                if (rx_valid) begin
                    state_d = (state_q == GOT_B0) ? GOT_B1 : IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        accept_b0 = (state_q == IDLE) && rx_valid && rx_data[SYNC];
        accept_b1 = (state_q == GOT_B0) && rx_valid;
        apply     = (state_q == GOT_B1) && rx_valid;

        left_b0_d = accept_b0 ? rx_data[LEFT]  : left_b0_q;
        xsign_d   = accept_b0 ? rx_data[XSIGN] : xsign_q;
        ysign_d   = accept_b0 ? rx_data[YSIGN] : ysign_q;
        dx_d      = accept_b1 ? rx_data        : dx_q;
`ifdef MOUSE_OVERFLOW_DISCARD_EN
        xovf_d    = accept_b0 ? rx_data[XOVF]  : xovf_q;
        yovf_d    = accept_b0 ? rx_data[YOVF]  : yovf_q;
`endif

        // Byte 2 is consumed straight from the bus in the apply cycle.
        dx9 = {xsign_q, dx_q};
        dy9 = {ysign_q, rx_data};
`ifdef MOUSE_OVERFLOW_DISCARD_EN
        if (xovf_q) dx9 = '0;
        if (yovf_q) dy9 = '0;
`endif
        dx_ext = {{4{dx9[8]}}, dx9};
        dy_neg = -{{4{dy9[8]}}, dy9};

        xpos_d   = apply ? x_new     : xpos_q;
        ypos_d   = apply ? y_new     : ypos_q;
        left_d   = apply ? left_b0_q : left_q;
        strobe_d = apply;
    end

    mouse_axis_clamp #(.MAX(X_MAX)) u_clamp_x (
        .pos    (xpos_q),
        .delta  (dx_ext),
        .result (x_new)
    );

    mouse_axis_clamp #(.MAX(Y_MAX)) u_clamp_y (
        .pos    (ypos_q),
        .delta  (dy_neg),
        .result (y_new)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            xpos_q   <= 12'(X_INIT);
            ypos_q   <= 12'(Y_INIT);
            left_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            left_q   <= left_d;
            strobe_q <= strobe_d;
        end
    end

    always_ff @(posedge pclk) begin
        left_b0_q <= left_b0_d;
        xsign_q   <= xsign_d;
        ysign_q   <= ysign_d;
        dx_q      <= dx_d;
`ifdef MOUSE_OVERFLOW_DISCARD_EN
        xovf_q    <= xovf_d;
        yovf_q    <= yovf_d;
`endif
    end

    assign xpos          = xpos_q;
    assign ypos          = ypos_q;
    assign left          = left_q;
    assign packet_strobe = strobe_q;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Bench for mouse_packet_decoder: directed packet table, framing corner cases and
// random traffic against a packet-level reference model.
module tb_mouse_packet_decoder;

    localparam int T  = 40;
    localparam int XI = 400;
    localparam int YI = 300;
    localparam int XM = 799;
    localparam int YM = 599;

    logic        pclk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [11:0] xpos, ypos;
    logic        left, packet_strobe;

    mouse_packet_decoder #(
        .X_MAX(XM), .Y_MAX(YM), .X_INIT(XI), .Y_INIT(YI), .TIMEOUT_CYCLES(T)
    ) dut (
        .pclk(pclk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .xpos(xpos), .ypos(ypos), .left(left), .packet_strobe(packet_strobe)
    );

    always #5 pclk = ~pclk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: bytes of the packet in progress and idle cycles since the last one.
    int         mx, my, gap;
    bit         ml, ms;
    logic [7:0] pq[$];

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         ex, ey;
        bit         el;
    } vec_t;

    vec_t tbl[18];

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        mx = XI; my = YI; ml = 0; ms = 0; gap = 0;
        pq.delete();
    endtask

    task automatic model_step(input bit v, input logic [7:0] d);
        int dx, dy;
        ms = 0;
        if (!v) begin
            if (pq.size() > 0) begin
                gap++;
                if (gap >= T) begin
                    pq.delete();
                    gap = 0;
                end
            end
        end else begin
            gap = 0;
            if (pq.size() == 0 && !d[3]) return;
            pq.push_back(d);
            if (pq.size() == 3) begin
                dx = int'(pq[1]) - (pq[0][4] ? 256 : 0);
                dy = int'(pq[2]) - (pq[0][5] ? 256 : 0);
`ifdef MOUSE_OVERFLOW_DISCARD_EN
                if (pq[0][6]) dx = 0;
                if (pq[0][7]) dy = 0;
`endif
                mx = clampi(mx + dx, XM);
                my = clampi(my - dy, YM);
                ml = pq[0][0];
                ms = 1;
                pq.delete();
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d required %0d", nm, $time, act, exp);
    endtask

    task automatic chk_model();
        chk("xpos", 32'(xpos), 32'(mx));
        chk("ypos", 32'(ypos), 32'(my));
        chk("left", 32'(left), 32'(ml));
        chk("strobe", 32'(packet_strobe), 32'(ms));
    endtask

    task automatic cyc(input bit v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = v ? d : 8'h00;
        model_step(v, d);
        @(posedge pclk);
        #1;
        chk_model();
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        cyc(1'b1, b0);
        cyc(1'b1, b1);
        cyc(1'b1, b2);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge pclk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_xpos", 32'(xpos), 32'(XI));
        chk("rst_ypos", 32'(ypos), 32'(YI));
        chk("rst_left", 32'(left), 32'd0);
        chk("rst_strobe", 32'(packet_strobe), 32'd0);
    endtask

    initial begin
        int ex;
        int r;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        tbl[0]  = '{8'h09, 8'h0A, 8'h05, 410, 295, 1'b1};
        tbl[1]  = '{8'h18, 8'h01, 8'h00, 155, 295, 1'b0};
        tbl[2]  = '{8'h18, 8'h6A, 8'h00,   5, 295, 1'b0};
        tbl[3]  = '{8'h18, 8'hF6, 8'h00,   0, 295, 1'b0};
        tbl[4]  = '{8'h08, 8'hFF, 8'h00, 255, 295, 1'b0};
        tbl[5]  = '{8'h08, 8'hFF, 8'h00, 510, 295, 1'b0};
        tbl[6]  = '{8'h08, 8'hFF, 8'h00, 765, 295, 1'b0};
        tbl[7]  = '{8'h08, 8'h1E, 8'h00, 795, 295, 1'b0};
        tbl[8]  = '{8'h08, 8'h7F, 8'h00, 799, 295, 1'b0};
        tbl[9]  = '{8'h28, 8'h00, 8'h01, 799, 550, 1'b0};
        tbl[10] = '{8'h28, 8'h00, 8'hD3, 799, 595, 1'b0};
        tbl[11] = '{8'h28, 8'h00, 8'hF0, 799, 599, 1'b0};
        tbl[12] = '{8'h08, 8'h00, 8'hFF, 799, 344, 1'b0};
        tbl[13] = '{8'h08, 8'h00, 8'hFF, 799,  89, 1'b0};
        tbl[14] = '{8'h08, 8'h00, 8'hFF, 799,   0, 1'b0};
        tbl[15] = '{8'h19, 8'h00, 8'h00, 543,   0, 1'b1};
`ifdef MOUSE_OVERFLOW_DISCARD_EN
        tbl[16] = '{8'h48, 8'h20, 8'h00, 543,   0, 1'b0};
        tbl[17] = '{8'hA8, 8'h00, 8'hE0, 543,   0, 1'b0};
`else
        tbl[16] = '{8'h48, 8'h20, 8'h00, 575,   0, 1'b0};
        tbl[17] = '{8'hA8, 8'h00, 8'hE0, 575,  32, 1'b0};
`endif

        do_reset();

        for (int i = 0; i < 18; i++) begin
            send3(tbl[i].b0, tbl[i].b1, tbl[i].b2);
            chk("tbl_xpos", 32'(xpos), 32'(tbl[i].ex));
            chk("tbl_ypos", 32'(ypos), 32'(tbl[i].ey));
            chk("tbl_left", 32'(left), 32'(tbl[i].el));
            chk("tbl_strobe", 32'(packet_strobe), 32'd1);
            if (i % 3 == 0) idle(1);
        end
        idle(1);
        chk("tbl_strobe_low", 32'(packet_strobe), 32'd0);

        // Stray byte without sync bit is dropped before a valid packet.
        ex = mx + 1;
        cyc(1'b1, 8'h00);
        send3(8'h08, 8'h01, 8'h01);
        chk("stray_xpos", 32'(xpos), 32'(ex));
        idle(2);

        // Partial packet abandoned after a full timeout interval.
        ex = mx + 1;
        cyc(1'b1, 8'h08);
        cyc(1'b1, 8'h05);
        idle(T);
        send3(8'h09, 8'h01, 8'h00);
        chk("tmo_xpos", 32'(xpos), 32'(ex));
        chk("tmo_left", 32'(left), 32'd1);
        idle(2);

        // Byte arriving on the last cycle before timeout still completes the packet.
        ex = mx + 3;
        cyc(1'b1, 8'h08);
        cyc(1'b1, 8'h03);
        idle(T - 1);
        cyc(1'b1, 8'h02);
        chk("edge_xpos", 32'(xpos), 32'(ex));
        chk("edge_strobe", 32'(packet_strobe), 32'd1);
        idle(2);

        // Reset in the middle of a packet.
        cyc(1'b1, 8'h08);
        cyc(1'b1, 8'h05);
        do_reset();
        send3(8'h08, 8'h02, 8'h00);
        chk("rstmid_xpos", 32'(xpos), 32'(XI + 2));
        chk("rstmid_ypos", 32'(ypos), 32'(YI));
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 6) idle($urandom_range(T - 2, T + 2));
            else if (r == 199) do_reset();
            else if (r < 120) cyc(1'b1, 8'($urandom));
            else cyc(1'b0, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
